priority_encoder_4x2_seq: RTL and testbench

PRIORITY_ENCODER_4X2_SEQ -- requirements
Module: priority_encoder_4x2_seq

---
 rtl/priority_encoder_4x2_seq.sv | 77 +++++++
 tb/tb_priority_encoder_4x2_seq.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/priority_encoder_4x2_seq.sv
// Sequential 4-to-2 priority encoder: captures a multi-hot request vector and
// emits the index of each set bit, highest priority (index 0) first, under valid/ready.
module priority_encoder_4x2_seq (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       load,
   input  logic [0:3] y_in,
   output logic       busy,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [1:0] code,
   output logic       last,
   output logic       zero
);

   typedef enum logic {
      ST_IDLE,
      ST_SERVE
   } state_t;

   state_t     r_state;
   logic [0:3] r_pending;
   logic       r_zero;

   logic [1:0] w_code;
   logic       w_single;
   logic       w_accept;

   // Index 0 wins; an empty register decodes to 2'b00.
   always_comb begin
      w_code = 2'b00;
      if (r_pending[0])      w_code = 2'd0;
      else if (r_pending[1]) w_code = 2'd1;
      else if (r_pending[2]) w_code = 2'd2;
      else if (r_pending[3]) w_code = 2'd3;
   end

   assign w_single  = $onehot(r_pending);
   assign out_valid = en && (r_state == ST_SERVE);
   assign w_accept  = out_valid && out_ready;

   assign busy = (r_state == ST_SERVE);
   assign code = w_code;
   assign last = out_valid && w_single;
   assign zero = r_zero;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_pending <= '0;
         r_zero    <= 1'b0;
      end else if (en) begin
         r_zero <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (load) begin
                  if (y_in != '0) begin
                     r_pending <= y_in;
                     r_state   <= ST_SERVE;
                  end else begin
                     r_zero <= 1'b1;
                  end
               end
            end
            ST_SERVE: begin
               // Loads are not looked at here, so a load on the final accept is dropped.
               if (w_accept) begin
                  r_pending[w_code] <= 1'b0;
                  if (w_single) r_state <= ST_IDLE;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_priority_encoder_4x2_seq.sv
// Bench for priority_encoder_4x2_seq: pending-set reference model checked every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_priority_encoder_4x2_seq;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       en = 1'b0;
   logic       load = 1'b0;
   logic [0:3] y_in = '0;
   logic       out_ready = 1'b0;
   logic       busy;
   logic       out_valid;
   logic [1:0] code;
   logic       last;
   logic       zero;

   int n_checks = 0;
   int n_errors = 0;

   logic [0:3] m_pending = '0;
   logic       m_zero = 1'b0;

   priority_encoder_4x2_seq dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .load      (load),
      .y_in      (y_in),
      .busy      (busy),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .code      (code),
      .last      (last),
      .zero      (zero)
   );

   always #5 clk = ~clk;

   function automatic int lowest_set(input logic [0:3] v);
      for (int i = 0; i < 4; i++)
         if (v[i]) return i;
      return 0;
   endfunction

   task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
      end
   endtask

   // Reference: the pending set; the block is serving exactly when it is non-empty.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_pending = '0;
         m_zero    = 1'b0;
      end else if (en) begin
         m_zero = 1'b0;
         if (m_pending == '0) begin
            if (load) begin
               if (y_in != '0) m_pending = y_in;
               else            m_zero = 1'b1;
            end
         end else if (out_ready) begin
            m_pending[lowest_set(m_pending)] = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      logic e_valid;
      e_valid = en && (m_pending != '0);
      chk("busy",      {3'b0, busy},      {3'b0, m_pending != '0});
      chk("out_valid", {3'b0, out_valid}, {3'b0, e_valid});
      chk("code",      {2'b0, code},      4'(lowest_set(m_pending)));
      chk("last",      {3'b0, last},      {3'b0, e_valid && ($countones(m_pending) == 1)});
      chk("zero",      {3'b0, zero},      {3'b0, m_zero});
   end

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   task automatic lit(input string name, input logic v, input logic b, input logic [1:0] c, input logic l);
      chk({name, ".valid"}, {3'b0, out_valid}, {3'b0, v});
      chk({name, ".busy"},  {3'b0, busy},      {3'b0, b});
      chk({name, ".code"},  {2'b0, code},      {2'b0, c});
      chk({name, ".last"},  {3'b0, last},      {3'b0, l});
   endtask

   initial begin
      #1 rst = 1'b1;
      #1;
      lit("reset", 1'b0, 1'b0, 2'b00, 1'b0);
      chk("reset.zero", {3'b0, zero}, 4'd0);
      cyc();
      cyc();
      rst = 1'b0;
      en  = 1'b1;

      // Full sweep
      load = 1'b1; y_in = 4'b1111; out_ready = 1'b1;
      cyc(); load = 1'b0;
      lit("sweep0", 1'b1, 1'b1, 2'b00, 1'b0);
      cyc(); lit("sweep1", 1'b1, 1'b1, 2'b01, 1'b0);
      cyc(); lit("sweep2", 1'b1, 1'b1, 2'b10, 1'b0);
      cyc(); lit("sweep3", 1'b1, 1'b1, 2'b11, 1'b1);
      cyc(); lit("sweep_end", 1'b0, 1'b0, 2'b00, 1'b0);

      // Backpressure
      load = 1'b1; y_in = 4'b0101; out_ready = 1'b0;
      cyc(); load = 1'b0;
      lit("bp_hold0", 1'b1, 1'b1, 2'b01, 1'b0);
      cyc(); lit("bp_hold1", 1'b1, 1'b1, 2'b01, 1'b0);
      cyc(); lit("bp_hold2", 1'b1, 1'b1, 2'b01, 1'b0);
      out_ready = 1'b1;
      cyc(); lit("bp_second", 1'b1, 1'b1, 2'b11, 1'b1);
      cyc(); lit("bp_end", 1'b0, 1'b0, 2'b00, 1'b0);

      // Zero load
      load = 1'b1; y_in = 4'b0000;
      cyc(); load = 1'b0;
      chk("zero_pulse", {3'b0, zero}, 4'd1);
      lit("zero_idle", 1'b0, 1'b0, 2'b00, 1'b0);
      cyc();
      chk("zero_clear", {3'b0, zero}, 4'd0);

      // Enable freeze with an ignored load
      load = 1'b1; y_in = 4'b0011; out_ready = 1'b0;
      cyc();
      lit("frz_loaded", 1'b1, 1'b1, 2'b10, 1'b0);
      en = 1'b0; out_ready = 1'b1; load = 1'b1; y_in = 4'b1000;
      cyc(); lit("frz0", 1'b0, 1'b1, 2'b10, 1'b0);
      cyc(); lit("frz1", 1'b0, 1'b1, 2'b10, 1'b0);
      en = 1'b1; load = 1'b0;
      #1 lit("frz_resume", 1'b1, 1'b1, 2'b10, 1'b0);
      cyc(); lit("frz_next", 1'b1, 1'b1, 2'b11, 1'b1);
      cyc(); lit("frz_end", 1'b0, 1'b0, 2'b00, 1'b0);

      // Single bit; load on the accept edge is dropped
      load = 1'b1; y_in = 4'b1000; out_ready = 1'b1;
      cyc();
      lit("single", 1'b1, 1'b1, 2'b00, 1'b1);
      y_in = 4'b1111;
      cyc(); lit("single_ignored", 1'b0, 1'b0, 2'b00, 1'b0);
      cyc(); load = 1'b0;
      lit("single_reload", 1'b1, 1'b1, 2'b00, 1'b0);
      repeat (4) cyc();
      lit("single_drain", 1'b0, 1'b0, 2'b00, 1'b0);

      // Reset mid-operation
      load = 1'b1; y_in = 4'b1011; out_ready = 1'b1;
      cyc(); load = 1'b0;
      lit("rst_first", 1'b1, 1'b1, 2'b00, 1'b0);
      cyc(); lit("rst_second", 1'b1, 1'b1, 2'b10, 1'b0);
      rst = 1'b1;
      #1 lit("rst_async", 1'b0, 1'b0, 2'b00, 1'b0);
      cyc();
      rst = 1'b0;
      cyc(); cyc();
      lit("rst_after", 1'b0, 1'b0, 2'b00, 1'b0);

      // Randomized traffic
      for (int n = 0; n < 1500; n++) begin
         en        = ($urandom_range(0, 7) != 0);
         load      = ($urandom_range(0, 2) == 0);
         y_in      = ($urandom_range(0, 5) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
         out_ready = ($urandom_range(0, 3) != 0);
         rst       = ($urandom_range(0, 199) == 0);
         cyc();
      end
      rst = 1'b0;
      cyc();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
